// File: rtl/dpram_param_if.sv
// dpram_param_if -- request/response bundle for the dual-port RAM dpram_param.
//
// Signals (per port x = a/b):
//   address_x  word address          wren_x   write request
//   wlane_x    per-lane write enable  rden_x   read request
//   data_x     write data             out_x    read data (held between reads)
//   valid_x    one-cycle strobe: out_x carries the data of one accepted read
//   collision  one-cycle strobe: both ports wrote the same in-range word
//   init_done  the array is accepting requests
//
// Handshake: there is no back-pressure. A request is accepted on any rising
// clk edge where init_done is 1. Every accepted read produces exactly one
// valid_x strobe a fixed latency later. Requests made while init_done is 0
// are dropped and never produce a strobe.
//
// Modports: master drives requests, slave (the RAM) drives responses.

interface dpram_param_if #(
    parameter int AWIDTH = 11,
    parameter int DWIDTH = 64,
    parameter int LANES  = 2
);
    logic [AWIDTH-1:0] address_a, address_b;
    logic              wren_a, wren_b;
    logic [LANES-1:0]  wlane_a, wlane_b;
    logic              rden_a, rden_b;
    logic [DWIDTH-1:0] data_a, data_b;
    logic [DWIDTH-1:0] out_a, out_b;
    logic              valid_a, valid_b;
    logic              collision;
    logic              init_done;

    modport master (
        output address_a, address_b, wren_a, wren_b, wlane_a, wlane_b,
               rden_a, rden_b, data_a, data_b,
        input  out_a, out_b, valid_a, valid_b, collision, init_done
    );

    modport slave (
        input  address_a, address_b, wren_a, wren_b, wlane_a, wlane_b,
               rden_a, rden_b, data_a, data_b,
        output out_a, out_b, valid_a, valid_b, collision, init_done
    );
endinterface

// File: rtl/dpram_param.sv
// dpram_param -- true dual-port RAM with per-lane write enables.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     dpram_param_if.slave (addresses, write/read requests, data,
//           read data + valid strobes, collision strobe, init_done)
//
// Parameters: AWIDTH address width, NUM_WORDS depth (<= 2**AWIDTH),
// DWIDTH data width (multiple of LANE), LANE lane width, OUT_REG adds one
// output register stage (read latency 1 + OUT_REG).
//
// Optional build macro DPRAM_CLEAR_EN: after reset a CLEAR -> READY FSM
// writes zero to every word, one per cycle, before init_done rises.
// Without it init_done rises on the first clk edge after reset release and
// the array contents are undefined until written.
//
// Reads are read-first: a read sees the array as it was before any write
// taking effect on the same edge, from either port. When both ports write
// the same word, port A owns every lane it enables.

module dpram_param #(
    parameter int AWIDTH    = 11,
    parameter int NUM_WORDS = 2048,
    parameter int DWIDTH    = 64,
    parameter int LANE      = 32,
    parameter int OUT_REG   = 0
) (
    input logic         clk,
    input logic         resetn,
    dpram_param_if.slave bus
);
    localparam int LANES = DWIDTH / LANE;
    localparam int IW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [AWIDTH:0] DEPTH = NUM_WORDS[AWIDTH:0];
    localparam logic [IW-1:0]   LAST  = IW'(NUM_WORDS - 1);

    logic [DWIDTH-1:0] mem [NUM_WORDS];

    logic              ready_q;
    logic              clr_we;
    logic [IW-1:0]     clr_cnt;

    logic              in_a, in_b;
    logic [IW-1:0]     idx_a, idx_b;
    logic              wr_a, wr_b, rd_a, rd_b;
    logic [DWIDTH-1:0] rdata_a, rdata_b;

    logic [DWIDTH-1:0] out_a_q, out_b_q;
    logic              valid_a_q, valid_b_q;
    logic              coll_q;

    // Out-of-range addresses never touch the array and read back as zero.
    assign in_a  = ({1'b0, bus.address_a} < DEPTH);
    assign in_b  = ({1'b0, bus.address_b} < DEPTH);
    assign idx_a = bus.address_a[IW-1:0];
    assign idx_b = bus.address_b[IW-1:0];

    assign wr_a = ready_q & bus.wren_a & in_a;
    assign wr_b = ready_q & bus.wren_b & in_b;
    assign rd_a = ready_q & bus.rden_a;
    assign rd_b = ready_q & bus.rden_b;

    assign rdata_a = in_a ? mem[idx_a] : '0;
    assign rdata_b = in_b ? mem[idx_b] : '0;

`ifdef DPRAM_CLEAR_EN
    typedef enum logic {S_CLEAR, S_READY} state_t;
    state_t state;

    // Reset (even mid-sweep) restarts the sweep at word 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state   <= S_READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we = (state == S_CLEAR);
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ready_q <= 1'b0;
        else         ready_q <= 1'b1;
    end

    assign clr_we  = 1'b0;
    assign clr_cnt = '0;
`endif

    // Array is never reset. Port B lanes are applied first so that a port A
    // write to the same word overrides exactly the lanes A enables.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_b && bus.wlane_b[l])
                    mem[idx_b][l*LANE +: LANE] <= bus.data_b[l*LANE +: LANE];
                if (wr_a && bus.wlane_a[l])
                    mem[idx_a][l*LANE +: LANE] <= bus.data_a[l*LANE +: LANE];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) coll_q <= 1'b0;
        else         coll_q <= wr_a & wr_b & (bus.address_a == bus.address_b);
    end

    // out_x only moves when a read completes; valid_x marks that cycle.
    generate
        if (OUT_REG == 0) begin : g_direct
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    valid_a_q <= 1'b0;
                    valid_b_q <= 1'b0;
                    out_a_q   <= '0;
                    out_b_q   <= '0;
                end else begin
                    valid_a_q <= rd_a;
                    valid_b_q <= rd_b;
                    if (rd_a) out_a_q <= rdata_a;
                    if (rd_b) out_b_q <= rdata_b;
                end
            end
        end else begin : g_piped
            logic              pv_a, pv_b;
            logic [DWIDTH-1:0] pd_a, pd_b;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    pv_a      <= 1'b0;
                    pv_b      <= 1'b0;
                    pd_a      <= '0;
                    pd_b      <= '0;
                    valid_a_q <= 1'b0;
                    valid_b_q <= 1'b0;
                    out_a_q   <= '0;
                    out_b_q   <= '0;
                end else begin
                    pv_a      <= rd_a;
                    pv_b      <= rd_b;
                    if (rd_a) pd_a <= rdata_a;
                    if (rd_b) pd_b <= rdata_b;
                    valid_a_q <= pv_a;
                    valid_b_q <= pv_b;
                    if (pv_a) out_a_q <= pd_a;
                    if (pv_b) out_b_q <= pd_b;
                end
            end
        end
    endgenerate

    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.valid_a   = valid_a_q;
    assign bus.valid_b   = valid_b_q;
    assign bus.collision = coll_q;
    assign bus.init_done = ready_q;
endmodule

// File: doc/dpram_param.md
DPRAM_PARAM -- requirements
Module: dpram_param

Interface
REQ-001 SHALL have parameter AWIDTH, default 11, address width.
REQ-002 SHALL have parameter NUM_WORDS, default 2048, depth (≤ 2**AWIDTH).
REQ-003 SHALL have parameter DWIDTH, default 64, data width; integer multiple of LANE.
REQ-004 SHALL have parameter LANE, default 32, lane width; LANES = DWIDTH/LANE.
REQ-005 SHALL have parameter OUT_REG, default 0, extra output register stage (0 or 1).
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 address_a / address_b  input  AWIDTH  port A/B word address.
REQ-009 wren_a / wren_b  input  1  port A/B write request.
REQ-010 wlane_a / wlane_b  input  LANES  per-lane write enable, qualified by wren.
REQ-011 rden_a / rden_b  input  1  port A/B read request.
REQ-012 data_a / data_b  input  DWIDTH  write data.
REQ-013 out_a / out_b  output  DWIDTH  read data.
REQ-014 valid_a / valid_b  output  1  out_x holds data for a read issued on that port.
REQ-015 collision  output  1  one-cycle pulse: both ports wrote the same address in one cycle.
REQ-016 init_done  output  1  array accepting requests.

Function
REQ-017 Read latency SHALL be 1 + OUT_REG cycles from the rden sample to valid/out update.
REQ-018 valid_x SHALL pulse high for exactly one cycle per accepted read; out_x SHALL hold its value until the next accepted read.
REQ-019 Writes SHALL update only lanes whose wlane bit is 1; other lanes keep their contents.
REQ-020 Same-port read and write at the same address SHALL return old data (read-first).
REQ-021 Cross-port read of an address written by the other port in the same cycle SHALL return old data.
REQ-022 Both ports writing the same address in one cycle: port A lanes SHALL win wherever wlane_a=1, port B lanes apply elsewhere; collision SHALL pulse 1 the following cycle.
REQ-023 Addresses ≥ NUM_WORDS SHALL be ignored for writes and return zero on reads (valid still pulses).
REQ-024 While init_done=0, wren/rden SHALL be ignored and valid_x SHALL stay 0.
REQ-025 Simultaneous read on both ports SHALL be serviced in parallel with no stall.

Reset
REQ-026 On resetn low: out_a=out_b=0, valid_a=valid_b=0, collision=0, OUT_REG pipeline cleared, in-flight reads discarded.
REQ-027 Array contents SHALL NOT be reset except via the clear feature.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge.

Configuration
REQ-029 Macro DPRAM_CLEAR_EN SHALL enable a post-reset clear FSM: states CLEAR -> READY.
REQ-030 With DPRAM_CLEAR_EN: reset enters CLEAR, counter from 0 writes all-zero to each word, one per cycle; after word NUM_WORDS-1, go to READY; init_done=1 from the cycle after the last clear write (NUM_WORDS cycles after reset release).
REQ-031 With DPRAM_CLEAR_EN, reset asserted mid-CLEAR SHALL restart the counter at 0.
REQ-032 Without DPRAM_CLEAR_EN: no FSM, init_done=1 from the first clk edge after reset release, contents undefined until written.

Verification
REQ-033 Write A addr 5 = 0x1122334455667788 with wlane=2'b11, read B addr 5 next cycle -> out_b=0x1122334455667788 and valid_b=1 exactly 1 cycle later (OUT_REG=0), 2 cycles later (OUT_REG=1).
REQ-034 Addr 7 holds 0xAAAAAAAABBBBBBBB; write 0x0000000011111111 with wlane=2'b01 -> read returns 0xAAAAAAAA11111111.
REQ-035 Same cycle: A writes addr 9 = 0x1 (wlane=01), B writes addr 9 = 0x2_00000002 (wlane=11) -> collision=1 the next cycle; addr 9 reads 0x0000000200000001.
REQ-036 Addr 3 holds 0x55; A writes addr 3 = 0x66 while B reads addr 3 in the same cycle -> out_b=0x55; a later read returns 0x66.
REQ-037 DPRAM_CLEAR_EN, NUM_WORDS=16: init_done=0 for 16 cycles after reset release; a rden during that window gives no valid; reads after init_done return 0 at all 16 addresses; reset pulsed at count 8 restarts the 16-cycle sequence.
REQ-038 Assert resetn low one cycle after a rden_a -> valid_a never pulses and out_a=0.
